core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle control FSM for the tiny RISC-V core. It fetches each 32-bit instruction over an 8-bit handshaked memory bus and holds it in the instruction register that feeds `instruction_decoder`. It then sequences execute, byte-serial load/store and writeback, and pulses the register-file and program-counter write enables once per instruction. Load data is assembled and extended here; store data is serialised here.

## Interface
- `ADDRESS_WIDTH`, 32, width of memory and program-counter addresses.
- `clock  in  1  rising-edge clock`
- `reset  in  1  asynchronous, active-high; clears all state and outputs`
- `run  in  1  high: keep executing; low: stop at the next instruction boundary`
- `program_counter  in  ADDRESS_WIDTH  current PC from datapath`
- `alu_result  in  32  ALU output; effective address for loads/stores`
- `store_data  in  32  rs2 value for stores`
- `control  in  control_t  decoder output for the held instruction`
- `memory_request  out  1  beat request`
- `memory_write  out  1  beat is a write`
- `memory_address  out  ADDRESS_WIDTH  beat byte address`
- `memory_write_data  out  8  write byte`
- `memory_ready  in  1  beat completes on a cycle with request && ready`
- `memory_read_data  in  8  read byte; valid when ready`
- `instruction  out  32  instruction register`
- `load_data  out  32  assembled, extended load value`
- `register_write_enable  out  1  one-cycle register-file write strobe`
- `program_counter_write_enable  out  1  one-cycle PC update strobe`
- `busy  out  1  high in any state except IDLE`

## Operation
- States:
  - IDLE: all strobes 0. Go to FETCH when `run`=1.
  - FETCH: 4 read beats at `program_counter`+k, k=0..3. Beat k writes `instruction[8k+:8]` (little-endian). After beat 3, go to EXECUTE.
  - EXECUTE: 1 cycle for decoder and ALU to settle. Latch `alu_result` into the address register and `store_data` into the store buffer. Go to MEMORY if `control.memory_write_enable` or `control.register_write_data_source==Memory`; otherwise go to WRITEBACK.
  - MEMORY: n beats at address+k. Size from `instruction[13:12]`: 00→1, 01→2, 10→4. Loads: beat k writes `load_buffer[8k+:8]`. Stores: `memory_write`=1, `memory_write_data`=`store_buffer[8k+:8]`. Size 11: zero beats, write suppressed.
  - WRITEBACK: `register_write_enable`=`control.register_write_enable` (0 for size-11 loads). `program_counter_write_enable`=1. Next state is FETCH if `run`, else IDLE.
- `load_data`:
  - funct3 000: sign-extend bit 7.
  - funct3 001: sign-extend bit 15.
  - funct3 100/101: zero-extend.
  - funct3 010: raw buffer.
  - Unused buffer bytes are cleared at MEMORY entry.
- No alignment checking. Addresses wrap modulo 2^ADDRESS_WIDTH.
- FENCE, SYSTEM and invalid opcodes decode to `control`=0. They complete with only the PC strobe.

## Timing
- Handshake:
  - `memory_request` stays high with address, write flag and data stable until ready.
  - Back-to-back beats keep request high and advance the address the cycle after completion.
  - `memory_ready` is ignored while request is low.
- Zero-wait-state latency:
  - ALU instruction: 6 cycles.
  - lb/sb: 7 cycles.
  - lh/sh: 8 cycles.
  - lw/sw: 10 cycles.
  - Each wait cycle adds 1.
- Strobes are one cycle wide, asserted in WRITEBACK only. `load_data` is valid that same cycle.
- `run` is sampled only in IDLE and WRITEBACK. Deasserting `run` mid-instruction finishes that instruction.
- Reset at any point:
  - State goes to IDLE.
  - `memory_request`, `memory_write`, both strobes and `busy` go to 0 immediately.
  - `instruction`, buffers and the beat counter clear to 0.
  - The partial beat is abandoned.
- Reset values: every output is 0.

## Structure
- `sequencer_states.svh` holds:
  - `sequencer_state_t` (IDLE, FETCH, EXECUTE, MEMORY, WRITEBACK)
  - access-size constants (`SIZE_BYTE`, `SIZE_HALFWORD`, `SIZE_WORD`)
- Reuses `control.svh` and `funct3.svh`.
- One sub-module, `memory_beat_engine`:
  - 2-bit beat counter, base address and beat count in.
  - Drives request, address and byte lanes.
  - Signals `done` on the final completed beat.

## Test plan
- Reset, `run`=1, zero-wait memory holding `addi x1,x0,5` (0x00500093) at PC 0 → beats at addresses 0..3. `instruction`=0x00500093. `register_write_enable` and `program_counter_write_enable` high together at cycle 6.
- `lb` from a byte 0x80 → one read beat at `alu_result`. `load_data`=0xFFFFFF80. Same byte with `lbu` → 0x00000080.
- `sw` with `store_data`=0xDEADBEEF at 0x100 → write beats 0xEF,0xBE,0xAD,0xDE at 0x100..0x103. `register_write_enable` stays 0.
- `memory_ready` low for 3 cycles on fetch beat 2 → address, request and data held stable. Total latency is 9 cycles.
- `run` dropped during MEMORY of `lw` → instruction completes, then IDLE with `busy`=0. No further requests.
- `reset` asserted mid-FETCH beat 1 → request drops the same cycle. `instruction`=0. Restart fetches from beat 0.

Source files
------------

// File: rtl/core_sequencer_pkg.sv
// Shared types for the core sequencer: FSM states, decoder control word,
// access-size encodings and load funct3 codes.
package core_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXECUTE,
    MEMORY,
    WRITEBACK
  } sequencer_state_t;

  // Memory access size as carried in instruction[13:12]
  localparam logic [1:0] SIZE_BYTE     = 2'b00;
  localparam logic [1:0] SIZE_HALFWORD = 2'b01;
  localparam logic [1:0] SIZE_WORD     = 2'b10;

  localparam logic [2:0] FETCH_BEATS = 3'd4;

  // Load funct3 codes that select the extension applied to load_data
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SRC_ALU,
    SRC_MEMORY,
    SRC_PC_PLUS_4,
    SRC_IMMEDIATE
  } register_write_data_source_t;

  // FENCE, SYSTEM and invalid opcodes decode to all zeros
  typedef struct packed {
    logic                        register_write_enable;
    register_write_data_source_t register_write_data_source;
    logic                        memory_write_enable;
  } control_t;

  // Number of byte beats for an access size; the reserved size moves nothing
  function automatic logic [2:0] access_beats(input logic [1:0] size);
    case (size)
      SIZE_BYTE:     return 3'd1;
      SIZE_HALFWORD: return 3'd2;
      SIZE_WORD:     return 3'd4;
      default:       return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/memory_beat_engine.sv
// Byte-serial beat engine: walks up to four consecutive byte addresses over
// the request/ready handshake, holding address and data until each beat lands.
module memory_beat_engine #(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     active,
  input  logic                     write,
  input  logic [ADDRESS_WIDTH-1:0] base_address,
  input  logic [2:0]               beat_count,
  input  logic [31:0]              write_data,
  input  logic                     memory_ready,
  output logic                     memory_request,
  output logic                     memory_write,
  output logic [ADDRESS_WIDTH-1:0] memory_address,
  output logic [7:0]               memory_write_data,
  output logic [1:0]               beat_index,
  output logic                     beat_fire,
  output logic                     done
);

  logic [1:0] beat_q, beat_d;

  // Bus drive and beat advance; the counter only moves on a completed beat
  always_comb begin
    memory_request    = active;
    memory_write      = active & write;
    memory_address    = active ? base_address + ADDRESS_WIDTH'(beat_q) : '0;
    memory_write_data = (active & write) ? write_data[{beat_q, 3'b000} +: 8] : 8'h00;
    beat_index        = beat_q;
    beat_fire         = active & memory_ready;
    done              = beat_fire & ({1'b0, beat_q} == beat_count - 3'd1);
    beat_d            = beat_q;
    if (beat_fire) beat_d = done ? 2'd0 : beat_q + 2'd1;
  end

  // Beat counter; reset abandons any partial access
  always_ff @(posedge clock or posedge reset) begin
    if (reset) beat_q <= 2'd0;
    else       beat_q <= beat_d;
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: byte-serial fetch, execute, optional byte-serial
// load/store, then a single writeback cycle carrying the RF and PC strobes.
//
// state     | meaning
// IDLE      | stopped, waiting for run
// FETCH     | four read beats at PC+0..3 into the instruction register
// EXECUTE   | decoder/ALU settle; latch effective address and store data
// MEMORY    | 1/2/4 load or store beats at address+k (none for size 11)
// WRITEBACK | RF/PC strobes; run decides FETCH or IDLE
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     run,
  input  logic [ADDRESS_WIDTH-1:0] program_counter,
  input  logic [31:0]              alu_result,
  input  logic [31:0]              store_data,
  input  control_t                 control,
  output logic                     memory_request,
  output logic                     memory_write,
  output logic [ADDRESS_WIDTH-1:0] memory_address,
  output logic [7:0]               memory_write_data,
  input  logic                     memory_ready,
  input  logic [7:0]               memory_read_data,
  output logic [31:0]              instruction,
  output logic [31:0]              load_data,
  output logic                     register_write_enable,
  output logic                     program_counter_write_enable,
  output logic                     busy
);

  sequencer_state_t         state_q, state_d;
  logic [31:0]              instruction_q, instruction_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [31:0]              store_buffer_q, store_buffer_d;
  logic [31:0]              load_buffer_q, load_buffer_d;

  logic                     engine_active, engine_write;
  logic [ADDRESS_WIDTH-1:0] engine_base;
  logic [2:0]               engine_count, access_count;
  logic [1:0]               beat_index;
  logic                     beat_fire, beat_done;
  logic                     is_store, is_load;

  assign is_store     = control.memory_write_enable;
  assign is_load      = (control.register_write_data_source == SRC_MEMORY) & ~is_store;
  assign access_count = access_beats(instruction_q[13:12]);
  assign instruction  = instruction_q;
  assign busy         = (state_q != IDLE);

  memory_beat_engine #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_beat_engine (
    .clock             (clock),
    .reset             (reset),
    .active            (engine_active),
    .write             (engine_write),
    .base_address      (engine_base),
    .beat_count        (engine_count),
    .write_data        (store_buffer_q),
    .memory_ready      (memory_ready),
    .memory_request    (memory_request),
    .memory_write      (memory_write),
    .memory_address    (memory_address),
    .memory_write_data (memory_write_data),
    .beat_index        (beat_index),
    .beat_fire         (beat_fire),
    .done              (beat_done)
  );

  // Next state, register updates, beat-engine steering and writeback strobes
  always_comb begin
    state_d                      = state_q;
    instruction_d                = instruction_q;
    address_d                    = address_q;
    store_buffer_d               = store_buffer_q;
    load_buffer_d                = load_buffer_q;
    engine_active                = 1'b0;
    engine_write                 = 1'b0;
    engine_base                  = address_q;
    engine_count                 = access_count;
    register_write_enable        = 1'b0;
    program_counter_write_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        engine_active = 1'b1;
        engine_base   = program_counter;
        engine_count  = FETCH_BEATS;
        if (beat_fire) instruction_d[{beat_index, 3'b000} +: 8] = memory_read_data;
        if (beat_done) state_d = EXECUTE;
      end
      EXECUTE: begin
        address_d      = ADDRESS_WIDTH'(alu_result);
        store_buffer_d = store_data;
        if (is_store || is_load) begin
          load_buffer_d = '0;
          state_d       = MEMORY;
        end else begin
          state_d = WRITEBACK;
        end
      end
      MEMORY: begin
        engine_active = (access_count != 3'd0);
        engine_write  = is_store;
        if (beat_fire && !is_store) load_buffer_d[{beat_index, 3'b000} +: 8] = memory_read_data;
        if (beat_done || access_count == 3'd0) state_d = WRITEBACK;
      end
      WRITEBACK: begin
        // A reserved-size load moved no data, so it must not write the RF
        register_write_enable        = control.register_write_enable &
                                       ~(is_load & (access_count == 3'd0));
        program_counter_write_enable = 1'b1;
        state_d                      = run ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load extension selected by the held instruction's funct3
  always_comb begin
    case (instruction_q[14:12])
      FUNCT3_LB:  load_data = {{24{load_buffer_q[7]}}, load_buffer_q[7:0]};
      FUNCT3_LH:  load_data = {{16{load_buffer_q[15]}}, load_buffer_q[15:0]};
      FUNCT3_LBU: load_data = {24'h000000, load_buffer_q[7:0]};
      FUNCT3_LHU: load_data = {16'h0000, load_buffer_q[15:0]};
      default:    load_data = load_buffer_q;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      instruction_q  <= '0;
      address_q      <= '0;
      store_buffer_q <= '0;
      load_buffer_q  <= '0;
    end else begin
      state_q        <= state_d;
      instruction_q  <= instruction_d;
      address_q      <= address_d;
      store_buffer_q <= store_buffer_d;
      load_buffer_q  <= load_buffer_d;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: byte memory plus a transaction-level model of
// the expected beats, writeback values and latency of each instruction.
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset, run;
  logic [31:0] program_counter, alu_result, store_data;
  control_t    control;
  logic        memory_request, memory_write, memory_ready;
  logic [31:0] memory_address;
  logic [7:0]  memory_write_data, memory_read_data;
  logic [31:0] instruction, load_data;
  logic        register_write_enable, program_counter_write_enable, busy;

  always #5 clock = ~clock;

  core_sequencer #(.ADDRESS_WIDTH(32)) dut (
    .clock                        (clock),
    .reset                        (reset),
    .run                          (run),
    .program_counter              (program_counter),
    .alu_result                   (alu_result),
    .store_data                   (store_data),
    .control                      (control),
    .memory_request               (memory_request),
    .memory_write                 (memory_write),
    .memory_address               (memory_address),
    .memory_write_data            (memory_write_data),
    .memory_ready                 (memory_ready),
    .memory_read_data             (memory_read_data),
    .instruction                  (instruction),
    .load_data                    (load_data),
    .register_write_enable        (register_write_enable),
    .program_counter_write_enable (program_counter_write_enable),
    .busy                         (busy)
  );

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [7:0]  data;
  } beat_t;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] mem [logic [31:0]];
  int         wait_plan [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic control_t mk_ctl(input logic rwe, input register_write_data_source_t src,
                                      input logic mwe);
    control_t c;
    c.register_write_enable      = rwe;
    c.register_write_data_source = src;
    c.memory_write_enable        = mwe;
    return c;
  endfunction

  task automatic clear_waits();
    for (int k = 0; k < 8; k++) wait_plan[k] = 0;
  endtask

  // Runs one instruction from IDLE; called and returns on a falling edge.
  task automatic run_instr(input logic [31:0] pc, input logic [31:0] word, input control_t ctl,
                           input logic [31:0] alu, input logic [31:0] sdata,
                           input int reset_beat, input bit drop_run, output int lat);
    beat_t       q[$];
    beat_t       b;
    logic [31:0] raw, exp_ld, a;
    logic [2:0]  f3;
    logic [7:0]  by;
    int          n, bi, wleft, cyc, wsum;
    bit          is_load, is_store, is_mem, seen, exp_rwe;

    f3       = word[14:12];
    is_store = ctl.memory_write_enable;
    is_load  = (ctl.register_write_data_source == SRC_MEMORY) && !is_store;
    is_mem   = is_load || is_store;
    case (f3[1:0])
      2'b00:   n = 1;
      2'b01:   n = 2;
      2'b10:   n = 4;
      default: n = 0;
    endcase
    if (!is_mem) n = 0;

    for (int k = 0; k < 4; k++) begin
      a      = pc + k;
      mem[a] = word[8*k +: 8];
      b.addr = a; b.wr = 1'b0; b.data = 8'h00;
      q.push_back(b);
    end
    raw = 0;
    for (int k = 0; k < n; k++) begin
      a = alu + k;
      b.addr = a;
      if (is_store) begin
        b.wr   = 1'b1;
        b.data = 8'((sdata >> (8*k)) & 32'hFF);
      end else begin
        if (mem.exists(a)) by = mem[a];
        else begin by = 8'($urandom); mem[a] = by; end
        raw    = raw + (32'(by) << (8*k));
        b.wr   = 1'b0;
        b.data = 8'h00;
      end
      q.push_back(b);
    end
    case (f3)
      3'b000:  exp_ld = (raw >= 32'd128)   ? raw - 32'd256   : raw;
      3'b001:  exp_ld = (raw >= 32'd32768) ? raw - 32'd65536 : raw;
      default: exp_ld = raw;
    endcase
    exp_rwe = ctl.register_write_enable && !(is_load && n == 0);
    wsum = 0;
    for (int k = 0; k < q.size(); k++) wsum += wait_plan[k];

    program_counter = pc;
    alu_result      = alu;
    store_data      = sdata;
    control         = ctl;
    memory_ready    = 1'b0;
    run             = 1'b1;
    bi = 0; wleft = wait_plan[0]; cyc = 0; seen = 0; lat = -1;

    while (!seen && cyc < 80) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (reset_beat >= 0 && memory_request && bi == reset_beat) begin
        memory_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("reset_request", memory_request, 0);
        chk("reset_write", memory_write, 0);
        chk("reset_busy", busy, 0);
        chk("reset_instruction", instruction, 0);
        run = 1'b0;
        return;
      end
      if (memory_request) begin
        if (bi < q.size()) begin
          chk($sformatf("beat%0d_addr", bi), memory_address, q[bi].addr);
          chk($sformatf("beat%0d_write", bi), memory_write, q[bi].wr);
          chk($sformatf("beat%0d_wdata", bi), memory_write_data, q[bi].data);
          if (drop_run && bi >= 4) run = 1'b0;
          if (wleft > 0) begin
            memory_ready = 1'b0;
            wleft--;
          end else begin
            memory_ready     = 1'b1;
            memory_read_data = mem.exists(q[bi].addr) ? mem[q[bi].addr] : 8'h00;
            bi++;
            wleft = (bi < 8) ? wait_plan[bi] : 0;
          end
        end else begin
          chk("extra_beat", bi, q.size());
          memory_ready = 1'b0;
        end
      end else begin
        memory_ready     = 1'($urandom_range(0, 1));
        memory_read_data = 8'($urandom);
      end
      if (program_counter_write_enable) begin
        seen = 1;
        lat  = cyc;
        chk("instruction", instruction, word);
        chk("register_write_enable", register_write_enable, exp_rwe);
        chk("beat_count", bi, q.size());
        if (is_load && n > 0) chk("load_data", load_data, exp_ld);
        if (!(is_mem && n == 0)) chk("latency", cyc, 6 + n + wsum);
        run = 1'b0;
      end else if (register_write_enable) begin
        chk("rwe_without_pc_strobe", register_write_enable, 0);
      end
    end
    chk("completed", seen, 1);
    memory_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("strobe_width", {program_counter_write_enable, register_write_enable}, 0);
    chk("busy_after", busy, 0);
    repeat (2) begin
      @(negedge clock);
      chk("idle_request", memory_request, 0);
    end
  endtask

  int          lat;
  logic [31:0] word, imm, pc, alu, sd;
  logic [2:0]  f3;
  logic [2:0]  load_f3 [5];
  control_t    ctl;

  initial begin
    load_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    reset = 1'b1; run = 1'b0; memory_ready = 1'b0; memory_read_data = 8'h00;
    program_counter = 0; alu_result = 0; store_data = 0; control = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_memory_request", memory_request, 0);
    chk("rst_memory_write", memory_write, 0);
    chk("rst_memory_address", memory_address, 0);
    chk("rst_memory_write_data", memory_write_data, 0);
    chk("rst_instruction", instruction, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_register_write_enable", register_write_enable, 0);
    chk("rst_pc_write_enable", program_counter_write_enable, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);

    // addi x1,x0,5 at PC 0
    clear_waits();
    run_instr(32'h0, 32'h00500093, mk_ctl(1, SRC_ALU, 0), 32'h0, 32'h0, -1, 0, lat);
    chk("addi_latency", lat, 6);

    // lb / lbu of byte 0x80
    mem[32'h200] = 8'h80;
    run_instr(32'h40, {12'h000, 5'd2, 3'b000, 5'd3, 7'b0000011}, mk_ctl(1, SRC_MEMORY, 0),
              32'h200, 32'h0, -1, 0, lat);
    chk("lb_latency", lat, 7);
    chk("lb_value", load_data, 32'hFFFFFF80);
    run_instr(32'h50, {12'h000, 5'd2, 3'b100, 5'd3, 7'b0000011}, mk_ctl(1, SRC_MEMORY, 0),
              32'h200, 32'h0, -1, 0, lat);
    chk("lbu_value", load_data, 32'h00000080);

    // sw 0xDEADBEEF to 0x100
    run_instr(32'h60, {7'd0, 5'd5, 5'd2, 3'b010, 5'd0, 7'b0100011}, mk_ctl(0, SRC_ALU, 1),
              32'h100, 32'hDEADBEEF, -1, 0, lat);
    chk("sw_latency", lat, 10);

    // three wait states on fetch beat 2
    wait_plan[2] = 3;
    run_instr(32'h80, 32'h00500093, mk_ctl(1, SRC_ALU, 0), 32'h0, 32'h0, -1, 0, lat);
    chk("fetch_wait_latency", lat, 9);
    clear_waits();

    // run dropped during the MEMORY beats of lw
    run_instr(32'hA0, {12'h000, 5'd2, 3'b010, 5'd3, 7'b0000011}, mk_ctl(1, SRC_MEMORY, 0),
              32'h300, 32'h0, -1, 1, lat);
    chk("lw_latency", lat, 10);

    // reset during fetch beat 1, then a clean restart
    run_instr(32'hC0, 32'h00500093, mk_ctl(1, SRC_ALU, 0), 32'h0, 32'h0, 1, 0, lat);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_busy", busy, 0);
    run_instr(32'hC0, 32'h00500093, mk_ctl(1, SRC_ALU, 0), 32'h0, 32'h0, -1, 0, lat);
    chk("restart_latency", lat, 6);

    // reserved-size load and store move nothing; load does not write the RF
    run_instr(32'hE0, {12'h000, 5'd2, 3'b011, 5'd3, 7'b0000011}, mk_ctl(1, SRC_MEMORY, 0),
              32'h400, 32'h0, -1, 0, lat);
    run_instr(32'hF0, {7'd0, 5'd5, 5'd2, 3'b011, 5'd0, 7'b0100011}, mk_ctl(0, SRC_ALU, 1),
              32'h400, 32'h12345678, -1, 0, lat);

    // FENCE: control is all zero, only the PC strobe
    run_instr(32'h110, 32'h0000000F, '0, 32'h0, 32'h0, -1, 0, lat);
    chk("fence_latency", lat, 6);

    // fetch across the top of the address space
    run_instr(32'hFFFFFFFE, 32'h00A00113, mk_ctl(1, SRC_ALU, 0), 32'h0, 32'h0, -1, 0, lat);

    // randomized mix with random wait states
    for (int it = 0; it < 40; it++) begin
      imm = $urandom; pc = $urandom; alu = $urandom; sd = $urandom;
      clear_waits();
      if ($urandom_range(0, 1) == 1)
        for (int k = 0; k < 8; k++) wait_plan[k] = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0: begin
          f3   = 3'($urandom_range(0, 7));
          word = {imm[11:0], 5'd1, f3, 5'd4, 7'b0010011};
          ctl  = mk_ctl(1, SRC_ALU, 0);
        end
        1: begin
          f3   = load_f3[$urandom_range(0, 4)];
          word = {imm[11:0], 5'd2, f3, 5'd3, 7'b0000011};
          ctl  = mk_ctl(1, SRC_MEMORY, 0);
        end
        2: begin
          f3   = 3'($urandom_range(0, 2));
          word = {imm[11:5], 5'd6, 5'd2, f3, imm[4:0], 7'b0100011};
          ctl  = mk_ctl(0, SRC_ALU, 1);
        end
        default: begin
          word = {imm[31:7], 7'b1110011};
          ctl  = '0;
        end
      endcase
      run_instr(pc, word, ctl, alu, sd, -1, 0, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
